// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, func codes,
// ALU control codes, FSM state encoding and the datapath control word.
package mips_multicycle_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_R_FORM = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI   = 6'h08;
  localparam logic [OP_W-1:0] OP_LW     = 6'h23;
  localparam logic [OP_W-1:0] OP_SW     = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'h04;
  localparam logic [OP_W-1:0] OP_J      = 6'h02;

  localparam logic [FUNC_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNC_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNC_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNC_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNC_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_RDATA2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_ED32    = 2'd2;
  localparam logic [1:0] SRCB_ED32_SH = 2'd3;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10
  } aluop_e;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_RWB    = 4'd8,
    S_EXEC_I = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  // Datapath enables and selects, ALU control excluded.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller.
interface mips_multicycle_ctrl_if;
  import mips_multicycle_ctrl_pkg::*;

  logic [OP_W-1:0]    Op;
  logic [FUNC_W-1:0]  Func;
  logic               Zero;
  logic               MemAck;
  logic               MemReq;
  logic               MemWrite;
  logic               IorD;
  logic               IRWrite;
  logic               PCWrite;
  logic [1:0]         PCSrc;
  logic               RegWrite;
  logic               RegDst;
  logic               MemToReg;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALU_W-1:0]   ALUCtrl;
  logic [STATE_W-1:0] State;
  logic               IllegalOp;

  modport master (
    input  Op, Func, Zero, MemAck,
    output MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDst,
           MemToReg, ALUSrcA, ALUSrcB, ALUCtrl, State, IllegalOp
  );

  modport slave (
    output Op, Func, Zero, MemAck,
    input  MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDst,
           MemToReg, ALUSrcA, ALUSrcB, ALUCtrl, State, IllegalOp
  );

endinterface

// File: rtl/mips_multicycle_ctrl_alu_dec.sv
// ALU control decoder: {ALUOp, Func} -> ALUCtrl, plus a flag telling whether
// Func names a supported R-form operation (independent of ALUOp).
module mips_alu_dec
  import mips_multicycle_ctrl_pkg::*;
(
  input  aluop_e              alu_op,
  input  logic [FUNC_W-1:0]   func,
  output logic [ALU_W-1:0]    alu_ctrl_c,
  output logic                func_legal_c
);

  logic [ALU_W-1:0] func_ctrl_c;

  // Func table, shared by EXEC_R control and DECODE legality check.
  always_comb begin
    func_ctrl_c  = ALU_ADD;
    func_legal_c = 1'b1;
    case (func)
      FN_ADD:  func_ctrl_c = ALU_ADD;
      FN_SUB:  func_ctrl_c = ALU_SUB;
      FN_AND:  func_ctrl_c = ALU_AND;
      FN_OR:   func_ctrl_c = ALU_OR;
      FN_SLT:  func_ctrl_c = ALU_SLT;
      default: func_legal_c = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctrl_c = ALU_ADD;
    case (alu_op)
      ALUOP_SUB:  alu_ctrl_c = ALU_SUB;
      ALUOP_FUNC: alu_ctrl_c = func_ctrl_c;
      default:    alu_ctrl_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared datapath, stalling on the memory req/ack handshake.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  mips_multicycle_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic             is_store_q, is_store_d;
  ctrl_t            ctrl_c;
  aluop_e           alu_op_c;
  logic             alu_en_c;
  logic [ALU_W-1:0] alu_ctrl_c;
  logic             func_legal_c;

  mips_alu_dec u_alu_dec (
    .alu_op       (alu_op_c),
    .func         (bus.Func),
    .alu_ctrl_c   (alu_ctrl_c),
    .func_legal_c (func_legal_c)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      illegal_q  <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      illegal_q  <= illegal_d;
      is_store_q <= is_store_d;
    end
  end

  // ALU operation per state; kept apart from the main FSM block so the
  // decoder's legality output can feed next-state logic without a loop.
  always_comb begin
    alu_op_c = ALUOP_ADD;
    alu_en_c = 1'b0;
    case (state_q)
      S_FETCH, S_DECODE, S_MEMADR, S_EXEC_I: alu_en_c = 1'b1;
      S_EXEC_R: begin
        alu_en_c = 1'b1;
        alu_op_c = ALUOP_FUNC;
      end
      S_BRANCH: begin
        alu_en_c = 1'b1;
        alu_op_c = ALUOP_SUB;
      end
      default: alu_en_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    is_store_d = is_store_q;
    ctrl_c     = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        ctrl_c.mem_req   = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        if (bus.MemAck) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          ctrl_c.pc_src   = PCSRC_ALU;
          state_d         = S_DECODE;
        end
      end

      // Branch target lands in ALUOut while the opcode is dispatched.
      S_DECODE: begin
        ctrl_c.alu_src_b = SRCB_ED32_SH;
        case (bus.Op)
          OP_LW: begin
            is_store_d = 1'b0;
            state_d    = S_MEMADR;
          end
          OP_SW: begin
            is_store_d = 1'b1;
            state_d    = S_MEMADR;
          end
          OP_R_FORM: begin
            if (func_legal_c) begin
              state_d = S_EXEC_R;
            end else begin
              illegal_d = 1'b1;
              state_d   = S_FETCH;
            end
          end
          OP_ADDI: state_d = S_EXEC_I;
          OP_BEQ:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_ED32;
        state_d          = is_store_q ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.iord    = 1'b1;
        if (bus.MemAck) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        state_d           = S_FETCH;
      end

      S_MEMWR: begin
        ctrl_c.mem_req   = 1'b1;
        ctrl_c.mem_write = 1'b1;
        ctrl_c.iord      = 1'b1;
        if (bus.MemAck) state_d = S_FETCH;
      end

      S_EXEC_R: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_RDATA2;
        state_d          = S_RWB;
      end

      S_RWB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b1;
        state_d          = S_FETCH;
      end

      S_EXEC_I: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_ED32;
        state_d          = S_IWB;
      end

      S_IWB: begin
        ctrl_c.reg_write = 1'b1;
        state_d          = S_FETCH;
      end

      S_BRANCH: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_RDATA2;
        ctrl_c.pc_write  = bus.Zero;
        ctrl_c.pc_src    = PCSRC_ALUOUT;
        state_d          = S_FETCH;
      end

      S_JUMP: begin
        ctrl_c.pc_write = 1'b1;
        ctrl_c.pc_src   = PCSRC_JUMP;
        state_d         = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.MemReq    = ctrl_c.mem_req;
  assign bus.MemWrite  = ctrl_c.mem_write;
  assign bus.IorD      = ctrl_c.iord;
  assign bus.IRWrite   = ctrl_c.ir_write;
  assign bus.PCWrite   = ctrl_c.pc_write;
  assign bus.PCSrc     = ctrl_c.pc_src;
  assign bus.RegWrite  = ctrl_c.reg_write;
  assign bus.RegDst    = ctrl_c.reg_dst;
  assign bus.MemToReg  = ctrl_c.mem_to_reg;
  assign bus.ALUSrcA   = ctrl_c.alu_src_a;
  assign bus.ALUSrcB   = ctrl_c.alu_src_b;
  assign bus.ALUCtrl   = alu_en_c ? alu_ctrl_c : ALU_W'(0);
  assign bus.State     = STATE_W'(state_q);
  assign bus.IllegalOp = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: the driver queues hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // {MemReq,MemWrite,IorD,IRWrite,PCWrite,PCSrc,RegWrite,RegDst,MemToReg,ALUSrcA,ALUSrcB,ALUCtrl}
  localparam logic [16:0] E_IDLE = 17'b0_0_0_0_0_00_0_0_0_0_00_0000;
  localparam logic [16:0] E_FA   = 17'b1_0_0_1_1_00_0_0_0_0_01_0010;
  localparam logic [16:0] E_FW   = 17'b1_0_0_0_0_00_0_0_0_0_01_0010;
  localparam logic [16:0] E_DEC  = 17'b0_0_0_0_0_00_0_0_0_0_11_0010;
  localparam logic [16:0] E_MADR = 17'b0_0_0_0_0_00_0_0_0_1_10_0010;
  localparam logic [16:0] E_MRD  = 17'b1_0_1_0_0_00_0_0_0_0_00_0000;
  localparam logic [16:0] E_MWB  = 17'b0_0_0_0_0_00_1_0_1_0_00_0000;
  localparam logic [16:0] E_MWR  = 17'b1_1_1_0_0_00_0_0_0_0_00_0000;
  localparam logic [16:0] E_XADD = 17'b0_0_0_0_0_00_0_0_0_1_00_0010;
  localparam logic [16:0] E_XSUB = 17'b0_0_0_0_0_00_0_0_0_1_00_0110;
  localparam logic [16:0] E_XAND = 17'b0_0_0_0_0_00_0_0_0_1_00_0000;
  localparam logic [16:0] E_XOR  = 17'b0_0_0_0_0_00_0_0_0_1_00_0001;
  localparam logic [16:0] E_XSLT = 17'b0_0_0_0_0_00_0_0_0_1_00_0111;
  localparam logic [16:0] E_RWB  = 17'b0_0_0_0_0_00_1_1_0_0_00_0000;
  localparam logic [16:0] E_XI   = 17'b0_0_0_0_0_00_0_0_0_1_10_0010;
  localparam logic [16:0] E_IWB  = 17'b0_0_0_0_0_00_1_0_0_0_00_0000;
  localparam logic [16:0] E_BRT  = 17'b0_0_0_0_1_01_0_0_0_1_00_0110;
  localparam logic [16:0] E_BRF  = 17'b0_0_0_0_0_01_0_0_0_1_00_0110;
  localparam logic [16:0] E_JMP  = 17'b0_0_0_0_1_10_0_0_0_0_00_0000;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [16:0] act_ctl;
  assign act_ctl = {bus.MemReq, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCWrite,
                    bus.PCSrc, bus.RegWrite, bus.RegDst, bus.MemToReg, bus.ALUSrcA,
                    bus.ALUSrcB, bus.ALUCtrl};

  // Monitor: one expectation per cycle, compared away from the active edge.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (bus.State !== e.st || act_ctl !== e.ctl || bus.IllegalOp !== e.ill) begin
        n_fail++;
        $display("FAIL %s: got state=%0d ctl=%b ill=%b, want state=%0d ctl=%b ill=%b",
                 e.name, bus.State, act_ctl, bus.IllegalOp, e.st, e.ctl, e.ill);
      end
    end
  end

  task automatic step(input string name, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic ack, input state_e st,
                      input logic [16:0] ctl, input logic ill);
    exp_t e;
    bus.Op     = op;
    bus.Func   = fn;
    bus.Zero   = z;
    bus.MemAck = ack;
    e.name = name;
    e.st   = 4'(st);
    e.ctl  = ctl;
    e.ill  = ill;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic run_r(input string name, input logic [5:0] fn,
                       input logic [16:0] xctl, input logic ill);
    step({name, "_fetch"}, OP_R_FORM, fn, 1'b0, 1'b1, S_FETCH,  E_FA,  ill);
    step({name, "_dec"},   OP_R_FORM, fn, 1'b0, 1'b1, S_DECODE, E_DEC, ill);
    step({name, "_exec"},  OP_R_FORM, fn, 1'b0, 1'b1, S_EXEC_R, xctl,  ill);
    step({name, "_wb"},    OP_R_FORM, fn, 1'b0, 1'b1, S_RWB,    E_RWB, ill);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Op = '0; bus.Func = '0; bus.Zero = 1'b0; bus.MemAck = 1'b1;
    @(posedge CLK);
    #1;
    step("reset", 6'h00, 6'h00, 1'b0, 1'b1, S_IDLE, E_IDLE, 1'b0);
    RST = 1'b0;
    step("idle", 6'h00, 6'h00, 1'b0, 1'b1, S_IDLE, E_IDLE, 1'b0);

    run_r("add", FN_ADD, E_XADD, 1'b0);
    run_r("sub", FN_SUB, E_XSUB, 1'b0);
    run_r("and", FN_AND, E_XAND, 1'b0);
    run_r("or",  FN_OR,  E_XOR,  1'b0);
    run_r("slt", FN_SLT, E_XSLT, 1'b0);

    step("addi_fetch", OP_ADDI, 6'h10, 1'b0, 1'b1, S_FETCH,  E_FA,  1'b0);
    step("addi_dec",   OP_ADDI, 6'h10, 1'b0, 1'b1, S_DECODE, E_DEC, 1'b0);
    step("addi_exec",  OP_ADDI, 6'h10, 1'b0, 1'b1, S_EXEC_I, E_XI,  1'b0);
    step("addi_wb",    OP_ADDI, 6'h10, 1'b0, 1'b1, S_IWB,    E_IWB, 1'b0);

    // LW with three ack-wait cycles in MEMRD: 8 cycles total.
    step("lw_fetch", OP_LW, 6'h00, 1'b0, 1'b1, S_FETCH,  E_FA,   1'b0);
    step("lw_dec",   OP_LW, 6'h00, 1'b0, 1'b1, S_DECODE, E_DEC,  1'b0);
    step("lw_adr",   OP_LW, 6'h00, 1'b0, 1'b1, S_MEMADR, E_MADR, 1'b0);
    for (int i = 0; i < 3; i++)
      step("lw_rd_wait", OP_LW, 6'h00, 1'b0, 1'b0, S_MEMRD, E_MRD, 1'b0);
    step("lw_rd_ack", OP_LW, 6'h00, 1'b0, 1'b1, S_MEMRD, E_MRD, 1'b0);
    step("lw_wb",     OP_LW, 6'h00, 1'b0, 1'b1, S_MEMWB, E_MWB, 1'b0);

    // SW with one fetch wait cycle.
    step("sw_fetch_wait", OP_SW, 6'h00, 1'b0, 1'b0, S_FETCH,  E_FW,   1'b0);
    step("sw_fetch",      OP_SW, 6'h00, 1'b0, 1'b1, S_FETCH,  E_FA,   1'b0);
    step("sw_dec",        OP_SW, 6'h00, 1'b0, 1'b1, S_DECODE, E_DEC,  1'b0);
    step("sw_adr",        OP_SW, 6'h00, 1'b0, 1'b1, S_MEMADR, E_MADR, 1'b0);
    step("sw_wr",         OP_SW, 6'h00, 1'b0, 1'b1, S_MEMWR,  E_MWR,  1'b0);

    step("beq1_fetch", OP_BEQ, 6'h00, 1'b1, 1'b1, S_FETCH,  E_FA,  1'b0);
    step("beq1_dec",   OP_BEQ, 6'h00, 1'b1, 1'b1, S_DECODE, E_DEC, 1'b0);
    step("beq1_br",    OP_BEQ, 6'h00, 1'b1, 1'b1, S_BRANCH, E_BRT, 1'b0);
    step("beq0_fetch", OP_BEQ, 6'h00, 1'b0, 1'b1, S_FETCH,  E_FA,  1'b0);
    step("beq0_dec",   OP_BEQ, 6'h00, 1'b0, 1'b1, S_DECODE, E_DEC, 1'b0);
    step("beq0_br",    OP_BEQ, 6'h00, 1'b0, 1'b1, S_BRANCH, E_BRF, 1'b0);

    step("j_fetch", OP_J, 6'h00, 1'b0, 1'b1, S_FETCH,  E_FA,  1'b0);
    step("j_dec",   OP_J, 6'h00, 1'b0, 1'b1, S_DECODE, E_DEC, 1'b0);
    step("j_jump",  OP_J, 6'h00, 1'b0, 1'b1, S_JUMP,   E_JMP, 1'b0);

    // Unsupported opcode, then unsupported R-form func; IllegalOp stays set.
    step("bad_op_fetch", 6'h3F, 6'h00, 1'b0, 1'b1, S_FETCH,  E_FA,  1'b0);
    step("bad_op_dec",   6'h3F, 6'h00, 1'b0, 1'b1, S_DECODE, E_DEC, 1'b0);
    step("bad_fn_fetch", OP_R_FORM, 6'h21, 1'b0, 1'b1, S_FETCH,  E_FA,  1'b1);
    step("bad_fn_dec",   OP_R_FORM, 6'h21, 1'b0, 1'b1, S_DECODE, E_DEC, 1'b1);
    run_r("add_sticky", FN_ADD, E_XADD, 1'b1);

    // Store stalled mid-handshake, then reset asserted inside the cycle.
    step("sw2_fetch", OP_SW, 6'h00, 1'b0, 1'b1, S_FETCH,  E_FA,   1'b1);
    step("sw2_dec",   OP_SW, 6'h00, 1'b0, 1'b1, S_DECODE, E_DEC,  1'b1);
    step("sw2_adr",   OP_SW, 6'h00, 1'b0, 1'b1, S_MEMADR, E_MADR, 1'b1);
    step("sw2_wait",  OP_SW, 6'h00, 1'b0, 1'b0, S_MEMWR,  E_MWR,  1'b1);
    RST = 1'b1;
    #1;
    step("rst_mid_store", OP_SW, 6'h00, 1'b0, 1'b0, S_IDLE, E_IDLE, 1'b0);
    RST = 1'b0;
    step("idle2", OP_R_FORM, FN_SUB, 1'b0, 1'b1, S_IDLE, E_IDLE, 1'b0);
    run_r("sub_after_rst", FN_SUB, E_XSUB, 1'b0);

    @(negedge CLK);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the MIPS core: sequences the shared datapath (PC, IR, register file, sign-extender, ALU, unified memory) through fetch/decode/execute/memory/write-back. It sits beside the JOIN datapath, sampling the IR opcode/func fields and the ALU zero flag, and drives every datapath enable and mux select. Memory is reached through a req/ack handshake, so the FSM stalls on slow memory.

## Interface
- No parameters. Opcodes, func codes, ALU codes and state encodings come from common_param.vh.
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- Op  in  6  IR[31:26]
- Func  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- MemAck  in  1  memory transfer complete, valid only while MemReq=1
- MemReq  out  1  memory access request
- MemWrite  out  1  store, qualifies MemReq
- IorD  out  1  address select: 0=PC, 1=ALUOut
- IRWrite  out  1  load IR
- PCWrite  out  1  load PC
- PCSrc  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target {PC[31:28],IR[25:0],2'b00}
- RegWrite  out  1  register file write
- RegDst  out  1  0=rt (IR[20:16]), 1=rd (IR[15:11])
- MemToReg  out  1  write-back source: 0=ALUOut, 1=MDR
- ALUSrcA  out  1  0=PC, 1=rdata1
- ALUSrcB  out  2  0=rdata2, 1=const 4, 2=ed32, 3=ed32<<2
- ALUCtrl  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- State  out  4  current state (debug)
- IllegalOp  out  1  sticky: unsupported opcode/func decoded

## Operation
- Supported: R_FORM (ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A), ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02.
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP.
- IDLE: all outputs 0; next cycle -> FETCH.
- FETCH: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=1, add. Hold until MemAck. On the MemAck cycle, IRWrite=1, PCWrite=1, PCSrc=0; -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, add (branch target into ALUOut). Branch on Op: LW/SW->MEMADR, R_FORM with legal Func->EXEC_R, ADDI->EXEC_I, BEQ->BRANCH, J->JUMP. Otherwise set IllegalOp, -> FETCH, no write.
- MEMADR: ALUSrcA=1, ALUSrcB=2, add; LW->MEMRD, SW->MEMWR.
- MEMRD: MemReq=1, IorD=1; on MemAck -> MEMWB. MEMWB: RegWrite=1, RegDst=0, MemToReg=1; -> FETCH.
- MEMWR: MemReq=1, MemWrite=1, IorD=1; on MemAck -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUCtrl from Func; -> RWB. RWB: RegWrite=1, RegDst=1, MemToReg=0; -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, add; -> IWB. IWB: RegWrite=1, RegDst=0, MemToReg=0; -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, sub; PCWrite=Zero, PCSrc=1; -> FETCH.
- JUMP: PCWrite=1, PCSrc=2; -> FETCH.
- Outputs not listed for a state are 0.

## Timing
- Outputs are combinational from State, except IRWrite/PCWrite in FETCH and state advance in memory states, which also depend on MemAck (same-cycle).
- Zero-wait memory (MemAck in the request cycle): R/ADDI 4 cycles, LW 5, SW 4, BEQ 3, J 3. Each ack-wait cycle adds 1.
- MemReq stays high and address selects stay stable until MemAck. MemAck while MemReq=0 is ignored.
- Op/Func are sampled only in DECODE and EXEC_R. IR is stable because IRWrite fires only in FETCH.
- RST asserted at any point: state -> IDLE immediately, every output 0, IllegalOp cleared. No write completes, including a store pending mid-handshake.
- IllegalOp clears only on RST.

## Structure
- common_param.vh: opcode/func localparams (R_FORM, ADDI, ADD, ...), ALUCtrl codes, 4-bit state encodings.
- Sub-module mips_alu_dec: combinational {ALUOp[1:0], Func} -> ALUCtrl, plus a legal-func flag.

## Test plan
- Reset, then release with MemAck=1 tied: IDLE one cycle, then FETCH with MemReq=1, PCWrite=1, IRWrite=1, then DECODE.
- R_FORM/ADD (t1=t2+t3), MemAck immediate: states FETCH, DECODE, EXEC_R (ALUCtrl=0010), RWB (RegWrite=1, RegDst=1); back in FETCH on the 5th edge.
- ADDI t1,t2,16: EXEC_I with ALUSrcB=2, then IWB with RegDst=0, RegWrite=1.
- LW with MemAck delayed 3 cycles in MEMRD: MemReq/IorD=1 held 3 cycles, RegWrite=0 until MEMWB, MemToReg=1; total 8 cycles.
- BEQ with Zero=1 gives PCWrite=1, PCSrc=1. Zero=0 gives PCWrite=0. J gives PCSrc=2.
- Op=0x3F: IllegalOp rises after DECODE, no RegWrite/MemWrite, FETCH resumes. Then assert RST in MEMWR: MemWrite drops immediately and IllegalOp clears.
